// File: rtl/ahb_lite_pkg.sv
// Shared AHB-lite encodings and the default-slave state type for the
// single-master interconnect.
package ahb_lite_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_e;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped NONSEQ/SEQ transfers with the two-cycle
// AHB ERROR response and keeps a sticky first-fault capture.
module ahb_default_slave
    import ahb_lite_pkg::*;
(
    input  logic              i_hclk,
    input  logic              i_hreset,
    input  logic              i_hready,
    input  logic              i_nomatch,
    input  logic [1:0]        i_htrans,
    input  logic [DATA_W-1:0] i_haddr,
    input  logic              i_hwrite,
    input  logic              i_clr,
    output logic              o_hready,
    output logic              o_hresp,
    output logic              o_flag,
    output logic [DATA_W-1:0] o_addr,
    output logic              o_write
);

    ds_state_e         r_state;
    logic              r_hready;
    logic              r_hresp;
    logic              r_flag;
    logic [DATA_W-1:0] r_addr;
    logic              r_write;

    logic w_active;
    logic w_start;
    logic w_capture;

    assign w_active  = (i_htrans == HTRANS_NONSEQ) || (i_htrans == HTRANS_SEQ);
    assign w_start   = i_hready && i_nomatch && w_active;
    assign w_capture = w_start && (r_state != DS_ERR1);

    // Outputs are registered alongside the state so the bus HREADY never loops
    // combinationally back through this block.
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_state  <= DS_IDLE;
            r_hready <= 1'b1;
            r_hresp  <= HRESP_OKAY;
        end else begin
            case (r_state)
                DS_IDLE: begin
                    if (w_start) begin
                        r_state  <= DS_ERR1;
                        r_hready <= 1'b0;
                        r_hresp  <= HRESP_ERROR;
                    end
                end
                DS_ERR1: begin
                    r_state  <= DS_ERR2;
                    r_hready <= 1'b1;
                    r_hresp  <= HRESP_ERROR;
                end
                DS_ERR2: begin
                    if (w_start) begin
                        r_state  <= DS_ERR1;
                        r_hready <= 1'b0;
                        r_hresp  <= HRESP_ERROR;
                    end else begin
                        r_state  <= DS_IDLE;
                        r_hready <= 1'b1;
                        r_hresp  <= HRESP_OKAY;
                    end
                end
                default: begin
                    r_state  <= DS_IDLE;
                    r_hready <= 1'b1;
                    r_hresp  <= HRESP_OKAY;
                end
            endcase
        end
    end

    // A fault arriving with the clear pulse is kept, so no fault is ever lost.
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_flag  <= 1'b0;
            r_addr  <= '0;
            r_write <= 1'b0;
        end else if (w_capture && (!r_flag || i_clr)) begin
            r_flag  <= 1'b1;
            r_addr  <= i_haddr;
            r_write <= i_hwrite;
        end else if (i_clr) begin
            r_flag  <= 1'b0;
            r_addr  <= '0;
            r_write <= 1'b0;
        end
    end

    assign o_hready = r_hready;
    assign o_hresp  = r_hresp;
    assign o_flag   = r_flag;
    assign o_addr   = r_addr;
    assign o_write  = r_write;

endmodule

// File: rtl/ahb_lite_xbar_n.sv
// Parametrised single-master AHB-lite interconnect: base/mask decode, registered
// data-phase response mux and a built-in error-returning default slave.
module ahb_lite_xbar_n
    import ahb_lite_pkg::*;
#(
    parameter int                       NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*32-1:0] ADDR_BASE  = {32'h4001_0000, 32'h4000_0000,
                                                      32'h2000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0] ADDR_MASK  = {4{32'hFFFF_0000}},
    parameter int                       ERR_IRQ_EN = 1
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    input  logic [DATA_W-1:0]            HADDR,
    input  logic [1:0]                   HTRANS,
    input  logic                         HWRITE,
    output logic                         HREADY,
    output logic [DATA_W-1:0]            HRDATA,
    output logic                         HRESP,
    output logic [NUM_SLAVES-1:0]        HSEL_S,
    output logic                         HREADY_S,
    input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
    input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]        HRESP_S,
    input  logic                         DECERR_CLR,
    output logic                         DECERR_FLAG,
    output logic [DATA_W-1:0]            DECERR_ADDR,
    output logic                         DECERR_WRITE,
    output logic                         DECERR_IRQ
);

    logic [NUM_SLAVES-1:0] w_raw;
    logic [NUM_SLAVES-1:0] w_hit;
    logic                  w_taken;
    logic                  w_nomatch;
    logic [NUM_SLAVES:0]   r_sel_dp;
    logic                  w_hready;
    logic                  w_hresp;
    logic [DATA_W-1:0]     w_hrdata;
    logic                  w_ds_hready;
    logic                  w_ds_hresp;

    always_comb begin
        w_raw = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_raw[i] = ((HADDR & ADDR_MASK[32*i +: 32]) == ADDR_BASE[32*i +: 32]);
        end
    end

    // Overlapping windows resolve to the lowest port so the select stays one-hot.
    always_comb begin
        w_hit   = '0;
        w_taken = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (w_raw[i] && !w_taken) begin
                w_hit[i] = 1'b1;
                w_taken  = 1'b1;
            end
        end
    end

    assign w_nomatch = ~|w_hit;
    assign HSEL_S    = w_hit;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_sel_dp <= '0;
        end else if (w_hready) begin
            r_sel_dp <= {w_nomatch, w_hit};
        end
    end

    always_comb begin
        w_hready = 1'b1;
        w_hresp  = HRESP_OKAY;
        w_hrdata = '0;
        if (r_sel_dp[NUM_SLAVES]) begin
            w_hready = w_ds_hready;
            w_hresp  = w_ds_hresp;
        end
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_sel_dp[i]) begin
                w_hready = HREADYOUT_S[i];
                w_hresp  = HRESP_S[i];
                w_hrdata = HRDATA_S[DATA_W*i +: DATA_W];
            end
        end
    end

    assign HREADY   = w_hready;
    assign HREADY_S = w_hready;
    assign HRESP    = w_hresp;
    assign HRDATA   = w_hrdata;

    ahb_default_slave u_default_slave (
        .i_hclk    (HCLK),
        .i_hreset  (HRESET),
        .i_hready  (w_hready),
        .i_nomatch (w_nomatch),
        .i_htrans  (HTRANS),
        .i_haddr   (HADDR),
        .i_hwrite  (HWRITE),
        .i_clr     (DECERR_CLR),
        .o_hready  (w_ds_hready),
        .o_hresp   (w_ds_hresp),
        .o_flag    (DECERR_FLAG),
        .o_addr    (DECERR_ADDR),
        .o_write   (DECERR_WRITE)
    );

    assign DECERR_IRQ = (ERR_IRQ_EN != 0) && DECERR_FLAG;

endmodule

// File: tb/tb_ahb_lite_xbar_n.sv
// Directed bench for the AHB-lite interconnect: four-port default build plus
// a two-port build with a catch-all window to exercise decode priority.
module tb_ahb_lite_xbar_n;
    import ahb_lite_pkg::*;

    logic         HCLK = 1'b0;
    logic         HRESET;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic         HWRITE;
    logic         HREADY;
    logic [31:0]  HRDATA;
    logic         HRESP;
    logic [3:0]   HSEL_S;
    logic         HREADY_S;
    logic [3:0]   HREADYOUT_S;
    logic [127:0] HRDATA_S;
    logic [3:0]   HRESP_S;
    logic         DECERR_CLR;
    logic         DECERR_FLAG;
    logic [31:0]  DECERR_ADDR;
    logic         DECERR_WRITE;
    logic         DECERR_IRQ;

    logic [31:0]  haddr2;
    logic [1:0]   htrans2;
    logic         hready2;
    logic [31:0]  hrdata2;
    logic         hresp2;
    logic [1:0]   hsel2;
    logic         hreadyS2;
    logic [63:0]  hrdataS2;
    logic         flag2;
    logic [31:0]  addr2;
    logic         write2;
    logic         irq2;

    int testCount = 0;
    int failCount = 0;

    always #5 HCLK = ~HCLK;

    ahb_lite_xbar_n dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .HADDR        (HADDR),
        .HTRANS       (HTRANS),
        .HWRITE       (HWRITE),
        .HREADY       (HREADY),
        .HRDATA       (HRDATA),
        .HRESP        (HRESP),
        .HSEL_S       (HSEL_S),
        .HREADY_S     (HREADY_S),
        .HREADYOUT_S  (HREADYOUT_S),
        .HRDATA_S     (HRDATA_S),
        .HRESP_S      (HRESP_S),
        .DECERR_CLR   (DECERR_CLR),
        .DECERR_FLAG  (DECERR_FLAG),
        .DECERR_ADDR  (DECERR_ADDR),
        .DECERR_WRITE (DECERR_WRITE),
        .DECERR_IRQ   (DECERR_IRQ)
    );

    ahb_lite_xbar_n #(
        .NUM_SLAVES (2),
        .ADDR_BASE  ({32'h0000_0000, 32'h2000_0000}),
        .ADDR_MASK  ({32'h0000_0000, 32'hFFFF_0000}),
        .ERR_IRQ_EN (0)
    ) dut2 (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .HADDR        (haddr2),
        .HTRANS       (htrans2),
        .HWRITE       (1'b0),
        .HREADY       (hready2),
        .HRDATA       (hrdata2),
        .HRESP        (hresp2),
        .HSEL_S       (hsel2),
        .HREADY_S     (hreadyS2),
        .HREADYOUT_S  (2'b11),
        .HRDATA_S     (hrdataS2),
        .HRESP_S      (2'b00),
        .DECERR_CLR   (1'b0),
        .DECERR_FLAG  (flag2),
        .DECERR_ADDR  (addr2),
        .DECERR_WRITE (write2),
        .DECERR_IRQ   (irq2)
    );

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drives the master address-phase signals, then lets combinational paths settle.
    task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] trans,
                                 input logic write);
        HADDR  = addr;
        HTRANS = trans;
        HWRITE = write;
        #1;
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        HRESET      = 1'b1;
        HADDR       = '0;
        HTRANS      = HTRANS_IDLE;
        HWRITE      = 1'b0;
        HREADYOUT_S = 4'hF;
        HRDATA_S    = '0;
        HRESP_S     = '0;
        DECERR_CLR  = 1'b0;
        haddr2      = '0;
        htrans2     = HTRANS_IDLE;
        hrdataS2    = {32'h2222_2222, 32'h1111_1111};
        step();
        step();
        HRESET = 1'b0;
        #1;
        checkOutput("reset_hready", {31'd0, HREADY}, 32'd1);
        checkOutput("reset_hresp", {31'd0, HRESP}, 32'd0);
        checkOutput("reset_hrdata", HRDATA, 32'h0);
        checkOutput("reset_flag", {31'd0, DECERR_FLAG}, 32'd0);

        // Mapped read on slave 1 with one wait state.
        applyStimulus(32'h2000_0010, HTRANS_NONSEQ, 1'b0);
        checkOutput("t1_hsel", {28'd0, HSEL_S}, 32'h2);
        step();
        HREADYOUT_S[1] = 1'b0;
        applyStimulus(32'h0, HTRANS_IDLE, 1'b0);
        checkOutput("t1_wait", {31'd0, HREADY}, 32'd0);
        step();
        HREADYOUT_S[1] = 1'b1;
        HRDATA_S[63:32] = 32'hDEAD_BEEF;
        #1;
        checkOutput("t1_ready", {31'd0, HREADY}, 32'd1);
        checkOutput("t1_rdata", HRDATA, 32'hDEAD_BEEF);
        checkOutput("t1_hresp", {31'd0, HRESP}, 32'd0);
        step();

        // Unmapped write: two-cycle ERROR and capture.
        applyStimulus(32'h5000_0000, HTRANS_NONSEQ, 1'b1);
        checkOutput("t2_hsel", {28'd0, HSEL_S}, 32'h0);
        step();
        applyStimulus(32'h0, HTRANS_IDLE, 1'b0);
        checkOutput("t2_c1_hready", {31'd0, HREADY}, 32'd0);
        checkOutput("t2_c1_hresp", {31'd0, HRESP}, 32'd1);
        checkOutput("t2_flag", {31'd0, DECERR_FLAG}, 32'd1);
        checkOutput("t2_addr", DECERR_ADDR, 32'h5000_0000);
        checkOutput("t2_write", {31'd0, DECERR_WRITE}, 32'd1);
        checkOutput("t2_irq", {31'd0, DECERR_IRQ}, 32'd1);
        step();
        checkOutput("t2_c2_hready", {31'd0, HREADY}, 32'd1);
        checkOutput("t2_c2_hresp", {31'd0, HRESP}, 32'd1);
        step();
        checkOutput("t2_after_hresp", {31'd0, HRESP}, 32'd0);

        // Clear, then first-fault semantics, then clear racing a new fault.
        DECERR_CLR = 1'b1;
        step();
        DECERR_CLR = 1'b0;
        #1;
        checkOutput("t3_clr_flag", {31'd0, DECERR_FLAG}, 32'd0);
        checkOutput("t3_clr_addr", DECERR_ADDR, 32'h0);
        applyStimulus(32'h5000_0000, HTRANS_NONSEQ, 1'b0);
        step();
        applyStimulus(32'h0, HTRANS_IDLE, 1'b0);
        step();
        step();
        applyStimulus(32'h6000_0004, HTRANS_NONSEQ, 1'b1);
        step();
        applyStimulus(32'h0, HTRANS_IDLE, 1'b0);
        step();
        step();
        checkOutput("t3_first_addr", DECERR_ADDR, 32'h5000_0000);
        checkOutput("t3_first_write", {31'd0, DECERR_WRITE}, 32'd0);
        applyStimulus(32'h7000_0000, HTRANS_NONSEQ, 1'b1);
        DECERR_CLR = 1'b1;
        step();
        DECERR_CLR = 1'b0;
        applyStimulus(32'h0, HTRANS_IDLE, 1'b0);
        checkOutput("t3_race_flag", {31'd0, DECERR_FLAG}, 32'd1);
        checkOutput("t3_race_addr", DECERR_ADDR, 32'h7000_0000);
        checkOutput("t3_race_write", {31'd0, DECERR_WRITE}, 32'd1);
        step();
        step();

        // Back-to-back errors, then an unmapped IDLE gets a zero-wait OKAY.
        applyStimulus(32'h5000_0000, HTRANS_NONSEQ, 1'b0);
        step();
        applyStimulus(32'h5000_0100, HTRANS_NONSEQ, 1'b0);
        checkOutput("t4_e1_hready", {31'd0, HREADY}, 32'd0);
        step();
        checkOutput("t4_e2_hready", {31'd0, HREADY}, 32'd1);
        checkOutput("t4_e2_hresp", {31'd0, HRESP}, 32'd1);
        step();
        applyStimulus(32'h5000_0000, HTRANS_IDLE, 1'b0);
        checkOutput("t4_again_hready", {31'd0, HREADY}, 32'd0);
        checkOutput("t4_again_hresp", {31'd0, HRESP}, 32'd1);
        checkOutput("t4_hold_addr", DECERR_ADDR, 32'h7000_0000);
        step();
        checkOutput("t4_again_e2", {31'd0, HRESP}, 32'd1);
        step();
        applyStimulus(32'h0, HTRANS_IDLE, 1'b0);
        checkOutput("t4_idle_hready", {31'd0, HREADY}, 32'd1);
        checkOutput("t4_idle_hresp", {31'd0, HRESP}, 32'd0);
        step();

        // Slave 0 stalls three cycles while slave 3's address phase is held.
        HRDATA_S[31:0]    = 32'hA0A0_0000;
        HRDATA_S[127:96]  = 32'h3333_3333;
        applyStimulus(32'h0000_0100, HTRANS_NONSEQ, 1'b0);
        checkOutput("t5_hsel0", {28'd0, HSEL_S}, 32'h1);
        step();
        HREADYOUT_S[0] = 1'b0;
        applyStimulus(32'h4001_0020, HTRANS_NONSEQ, 1'b0);
        checkOutput("t5_hsel3", {28'd0, HSEL_S}, 32'h8);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t5_stall_hready", {31'd0, HREADY_S}, 32'd0);
            checkOutput("t5_stall_rdata", HRDATA, 32'hA0A0_0000);
            step();
        end
        HREADYOUT_S[0] = 1'b1;
        #1;
        checkOutput("t5_s0_done", HRDATA, 32'hA0A0_0000);
        step();
        applyStimulus(32'h0, HTRANS_IDLE, 1'b0);
        checkOutput("t5_s3_rdata", HRDATA, 32'h3333_3333);
        step();

        // Overlapping windows: port 0 must win; catch-all port 1 otherwise.
        haddr2  = 32'h2000_0004;
        htrans2 = HTRANS_NONSEQ;
        #1;
        checkOutput("t5_ovl_hsel", {30'd0, hsel2}, 32'h1);
        haddr2 = 32'h9000_0000;
        #1;
        checkOutput("t5_catch_hsel", {30'd0, hsel2}, 32'h2);
        step();
        htrans2 = HTRANS_IDLE;
        #1;
        checkOutput("t5_catch_rdata", hrdata2, 32'h2222_2222);

        // Reset while the default slave is in its first error cycle.
        applyStimulus(32'h5000_0000, HTRANS_NONSEQ, 1'b0);
        step();
        applyStimulus(32'h0, HTRANS_IDLE, 1'b0);
        checkOutput("t6_err1", {31'd0, HREADY}, 32'd0);
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        #1;
        checkOutput("t6_hready", {31'd0, HREADY}, 32'd1);
        checkOutput("t6_hresp", {31'd0, HRESP}, 32'd0);
        checkOutput("t6_flag", {31'd0, DECERR_FLAG}, 32'd0);
        step();
        checkOutput("t6_idle_hresp", {31'd0, HRESP}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/ahb_lite_xbar_n.md
Name: ahb_lite_xbar_n

Overview:
- Parametrised single-master AHB-lite interconnect for the Cortex-M0 subsystem. It replaces the fixed four-port interconnect.
- Decodes HADDR against a per-port base/mask table and broadcasts the shared HREADY to all slaves.
- Muxes slave responses using a registered data-phase select.
- Contains a built-in default slave that returns the AHB two-cycle ERROR for unmapped accesses and records the faulting access in a sticky status capture with an IRQ output.

Parameters:
- NUM_SLAVES, 4, number of slave ports (1..16).
- ADDR_BASE, {32'h4001_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000}, packed NUM_SLAVES*32 base addresses, port 0 in LSBs.
- ADDR_MASK, {4{32'hFFFF_0000}}, packed NUM_SLAVES*32 decode masks.
- ERR_IRQ_EN, 1, 1 = drive DECERR_IRQ from the sticky flag; 0 = tie DECERR_IRQ low.

Ports:
- HCLK  in  1  bus clock
- HRESET  in  1  synchronous, active-high reset
- HADDR  in  32  master address
- HTRANS  in  2  master transfer type
- HWRITE  in  1  master write
- HREADY  out  1  to master and broadcast to all slaves as HREADY_S
- HRDATA  out  32  to master
- HRESP  out  1  to master
- HSEL_S  out  NUM_SLAVES  slave selects (address phase, combinational)
- HREADY_S  out  1  shared HREADY to slaves
- HREADYOUT_S  in  NUM_SLAVES  slave ready outputs
- HRDATA_S  in  NUM_SLAVES*32  packed slave read data
- HRESP_S  in  NUM_SLAVES  slave responses
- DECERR_CLR  in  1  single-cycle pulse, clears the sticky error capture
- DECERR_FLAG  out  1  sticky unmapped-access flag
- DECERR_ADDR  out  32  address of the first unmapped access since clear
- DECERR_WRITE  out  1  HWRITE of that access
- DECERR_IRQ  out  1  DECERR_FLAG & ERR_IRQ_EN

Behaviour:
- Decode: hit[i] = ((HADDR & MASK_i) == BASE_i).
  - On overlapping hits the lowest index wins; the result is one-hot.
  - HSEL_S = one-hot hit, independent of HTRANS.
  - nomatch = ~|hit.
- Data-phase select sel_dp (NUM_SLAVES+1 bits, MSB = default slave):
  - Loads {nomatch, hit} when HREADY=1; holds otherwise.
  - Reset value 0 (nothing selected).
- Response mux:
  - sel_dp = 0: HREADY=1, HRESP=0, HRDATA=0.
  - Slave i selected: HREADY=HREADYOUT_S[i], HRESP=HRESP_S[i], HRDATA=HRDATA_S[i].
  - Default slave selected: HRDATA=0; HREADY and HRESP come from the default-slave FSM.
- Default-slave FSM (states IDLE, ERR1, ERR2; reset → IDLE):
  - IDLE: if HREADY & nomatch & HTRANS[1] → ERR1. An unmapped IDLE or BUSY transfer stays in IDLE and gets a zero-wait OKAY (HREADY=1, HRESP=0).
  - ERR1: drives HREADY=0, HRESP=1; unconditionally → ERR2.
  - ERR2: drives HREADY=1, HRESP=1.
    - A new address phase is sampled here.
    - If that phase is unmapped with HTRANS[1] → ERR1, else → IDLE.
- Latency:
  - Unmapped NONSEQ/SEQ: exactly 2 data-phase cycles.
  - Mapped: the slave's own latency; the interconnect adds zero wait states.
- Capture: on the IDLE→ERR1 or ERR2→ERR1 transition:
  - If DECERR_FLAG=0: load DECERR_ADDR=HADDR and DECERR_WRITE=HWRITE, and set DECERR_FLAG.
  - If DECERR_FLAG=1: address and write capture hold (first-fault semantics).
- DECERR_CLR:
  - Clears FLAG, ADDR and WRITE to 0.
  - A capture in the same cycle as DECERR_CLR wins: FLAG stays 1 and the new address is loaded.
- Reset (HRESET=1 at a clock edge):
  - sel_dp=0, FSM=IDLE, all DECERR_* =0.
  - Outputs therefore read HREADY=1, HRESP=0, HRDATA=0.
  - An in-flight error sequence or slave transfer is abandoned.
- Width rules: the packed bus slice for port i is [32*i+31 : 32*i]. NUM_SLAVES=1 is legal.

Decomposition:
- Package ahb_lite_pkg:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ).
  - HRESP OKAY/ERROR constants.
  - Default-slave state enum.
  - Data width constant 32.
- Sub-module ahb_default_slave: the FSM plus the capture registers. The decode and mux logic stays in the top.

Test Plan:
1. Mapped read: NONSEQ read 0x2000_0010, slave 1 returns 0xDEADBEEF with 1 wait state → HSEL_S=4'b0010; master sees HREADY low 1 cycle then HRDATA=0xDEADBEEF, HRESP=0.
2. Unmapped write: NONSEQ write 0x5000_0000 → cycle 1 HREADY=0/HRESP=1, cycle 2 HREADY=1/HRESP=1; DECERR_FLAG=1, DECERR_ADDR=0x5000_0000, DECERR_WRITE=1, DECERR_IRQ=1.
3. First-fault plus clear: unmapped 0x5000_0000 then 0x6000_0004 → ADDR stays 0x5000_0000. Pulse DECERR_CLR concurrently with a third unmapped access at 0x7000_0000 → FLAG=1, ADDR=0x7000_0000.
4. Back-to-back error: keep HTRANS=NONSEQ unmapped during ERR2 → FSM goes ERR2→ERR1 and a second full 2-cycle ERROR follows; unmapped HTRANS=IDLE gives an OKAY zero-wait response.
5. Pipelining/overlap:
   - Alternate slave 0 and slave 3 accesses back-to-back while slave 0 stalls 3 cycles → slave 3's address phase is held; the data mux switches only when HREADY=1.
   - Overlap check with NUM_SLAVES=2 and port 1 mask 0 (matches everything) → port 0 wins on overlap.
6. Reset mid-ERR1: assert HRESET during ERR1 → next cycle HREADY=1, HRESP=0, DECERR_FLAG=0, FSM IDLE.
